// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and exception redirects in,
// stall bus, flush pulse, redirect PC and debug counters out.
interface pipeline_ctrl_if;
    logic        stall_req_if;
    logic        stall_req_id;
    logic        stall_req_ex;
    logic        stall_req_mem;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_ready;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_count;
    logic        stall_timeout;

    // Pipeline/exception-unit side
    modport master (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        output redirect_valid, redirect_target,
        input  redirect_ready, stall, flush, new_pc, stall_count, stall_timeout
    );

    // Controller side
    modport slave (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        input  redirect_valid, redirect_target,
        output redirect_ready, stall, flush, new_pc, stall_count, stall_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall-bus merge, redirect/flush sequencing
// deferred behind in-flight memory accesses, stall counter and watchdog.
module pipeline_ctrl #(
    parameter int unsigned STALL_LIMIT = 255
) (
    input logic           clock,
    input logic           reset,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RUN_W   = 16;
    localparam int unsigned STALL_W = 6;

    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [ADDR_W-1:0]   new_pc_q, new_pc_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                timeout_q, timeout_d;
    logic [STALL_W-1:0]  stall_c;
    logic [STALL_W-1:0]  stall_enc_c;
    logic                ready_c;

    // Highest requesting stage holds itself and everything upstream
    always_comb begin
        stall_enc_c = '0;
        if (bus.stall_req_mem)     stall_enc_c = 6'b011111;
        else if (bus.stall_req_ex) stall_enc_c = 6'b001111;
        else if (bus.stall_req_id) stall_enc_c = 6'b000111;
        else if (bus.stall_req_if) stall_enc_c = 6'b000011;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        new_pc_d = new_pc_q;
        ready_c  = 1'b0;
        stall_c  = stall_enc_c;

        case (state_q)
            ST_RUN: begin
                ready_c = ~bus.stall_req_mem;
                if (bus.redirect_valid) begin
                    target_d = bus.redirect_target;
                    if (bus.stall_req_mem) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d  = ST_FLUSH;
                        new_pc_d = bus.redirect_target;
                    end
                end
            end
            ST_PEND: begin
                if (!bus.stall_req_mem) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = target_q;
                end
            end
            ST_FLUSH: begin
                stall_c = '0;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        if (reset) begin
            stall_c = '0;
            ready_c = 1'b0;
        end

        // Counters see exactly the stall value driven this cycle
        stall_count_d = stall_count_q;
        if (stall_c[0] && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);

        run_d = '0;
        if (stall_c[0])
            run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);

        timeout_d = timeout_q | (32'(run_d) >= 32'(STALL_LIMIT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            target_q      <= '0;
            new_pc_q      <= '0;
            stall_count_q <= '0;
            run_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            new_pc_q      <= new_pc_d;
            stall_count_q <= stall_count_d;
            run_q         <= run_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.stall          = stall_c;
    assign bus.redirect_ready = ready_c;
    assign bus.flush          = (state_q == ST_FLUSH);
    assign bus.new_pc         = new_pc_q;
    assign bus.stall_count    = stall_count_q;
    assign bus.stall_timeout  = timeout_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: cycle-level reference model checked every cycle,
// plus literal pins taken from hand-worked scenarios.
module tb_pipeline_ctrl;
    localparam int unsigned LIMIT = 4;

    logic clock;
    logic reset;
    pipeline_ctrl_if bus();

    pipeline_ctrl #(.STALL_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit          started  = 0;
    bit          m_flush  = 0;
    bit          m_pend   = 0;
    logic [31:0] m_pend_t = '0;
    logic [31:0] m_newpc  = '0;
    longint      m_cnt    = 0;
    int          m_run    = 0;
    bit          m_to     = 0;
    bit          preload  = 0;

    // Literal pins: 0 stall,1 ready,2 flush,3 new_pc,4 count,5 timeout
    bit          pin_en [6];
    logic [63:0] pin_val[6];

    function automatic int depth();
        if (bus.stall_req_mem) return 5;
        if (bus.stall_req_ex)  return 4;
        if (bus.stall_req_id)  return 3;
        if (bus.stall_req_if)  return 2;
        return 0;
    endfunction

    function automatic logic [5:0] e_stall();
        if (reset || m_flush) return 6'd0;
        return 6'((1 << depth()) - 1);
    endfunction

    function automatic logic e_ready();
        return !reset && !m_flush && !m_pend && !bus.stall_req_mem;
    endfunction

    always @(posedge clock) begin
        longint base;
        int     nrun;
        logic [5:0] s;
        if (reset) begin
            started <= 1;
            m_flush <= 0;
            m_pend  <= 0;
            m_newpc <= '0;
            m_cnt   <= 0;
            m_run   <= 0;
            m_to    <= 0;
        end else begin
            s    = e_stall();
            base = preload ? 64'hFFFF_FFFE : m_cnt;
            m_cnt <= (base + longint'(s[0]) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : base + longint'(s[0]);
            nrun = s[0] ? ((m_run + 1 > 65535) ? 65535 : m_run + 1) : 0;
            m_run <= nrun;
            m_to  <= m_to || (nrun >= int'(LIMIT));
            if (m_flush) begin
                m_flush <= 0;
            end else if (m_pend) begin
                if (!bus.stall_req_mem) begin
                    m_flush <= 1;
                    m_newpc <= m_pend_t;
                    m_pend  <= 0;
                end
            end else if (bus.redirect_valid) begin
                if (bus.stall_req_mem) begin
                    m_pend   <= 1;
                    m_pend_t <= bus.redirect_target;
                end else begin
                    m_flush <= 1;
                    m_newpc <= bus.redirect_target;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] actual(input int k);
        case (k)
            0: return 64'(bus.stall);
            1: return 64'(bus.redirect_ready);
            2: return 64'(bus.flush);
            3: return 64'(bus.new_pc);
            4: return 64'(bus.stall_count);
            default: return 64'(bus.stall_timeout);
        endcase
    endfunction

    // Single compare process: model every cycle, plus any literal pins
    always @(negedge clock) begin
        if (started) begin
            chk("stall",         64'(bus.stall),          64'(e_stall()));
            chk("ready",         64'(bus.redirect_ready), 64'(e_ready()));
            chk("flush",         64'(bus.flush),          64'(m_flush));
            chk("new_pc",        64'(bus.new_pc),         64'(m_newpc));
            chk("stall_count",   64'(bus.stall_count),    64'(m_cnt));
            chk("stall_timeout", 64'(bus.stall_timeout),  64'(m_to));
            for (int k = 0; k < 6; k++)
                if (pin_en[k]) chk($sformatf("pin%0d", k), actual(k), pin_val[k]);
        end
    end

    // req bits: 0 if, 1 id, 2 ex, 3 mem
    task automatic drive(input logic [3:0] req, input logic v, input logic [31:0] t, input logic rst);
        reset               = rst;
        bus.stall_req_if    = req[0];
        bus.stall_req_id    = req[1];
        bus.stall_req_ex    = req[2];
        bus.stall_req_mem   = req[3];
        bus.redirect_valid  = v;
        bus.redirect_target = t;
        for (int k = 0; k < 6; k++) pin_en[k] = 0;
    endtask

    task automatic pin(input int k, input logic [63:0] v);
        pin_en[k]  = 1;
        pin_val[k] = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 6; k++) begin pin_en[k] = 0; pin_val[k] = '0; end
        drive(4'b0000, 0, '0, 1); tick();
        drive(4'b0000, 0, '0, 1); pin(0, 0); pin(1, 0); tick();
        drive(4'b0000, 0, '0, 0); pin(2, 0); pin(3, 0); pin(4, 0); pin(5, 0); tick();

        // Stall priority
        drive(4'b0011, 0, '0, 0); pin(0, 64'b000111); tick();
        drive(4'b1011, 0, '0, 0); pin(0, 64'b011111); pin(1, 0); tick();
        drive(4'b0000, 0, '0, 0); pin(0, 0); tick();

        // Immediate redirect, stall masked during flush then re-applied
        drive(4'b0000, 1, 32'h0000_0380, 0); pin(1, 1); tick();
        drive(4'b0010, 0, '0, 0); pin(2, 1); pin(3, 32'h380); pin(0, 0); tick();
        drive(4'b0010, 0, '0, 0); pin(2, 0); pin(0, 64'b000111); tick();
        drive(4'b0000, 0, '0, 0); tick();

        // Back-to-back redirects with valid held high
        drive(4'b0000, 1, 32'h0000_0100, 0); pin(1, 1); tick();
        drive(4'b0000, 1, 32'h0000_0200, 0); pin(1, 0); pin(3, 32'h100); tick();
        drive(4'b0000, 1, 32'h0000_0200, 0); pin(1, 1); tick();
        drive(4'b0000, 0, '0, 0); pin(2, 1); pin(3, 32'h200); tick();

        // Deferred redirect: first target wins
        drive(4'b1000, 1, 32'hBFC0_0000, 0); pin(1, 0); pin(0, 64'b011111); tick();
        repeat (3) begin
            drive(4'b1000, 1, 32'h0000_1234, 0); pin(1, 0); pin(2, 0); tick();
        end
        drive(4'b0000, 0, '0, 0); pin(2, 0); pin(1, 0); tick();
        drive(4'b0000, 0, '0, 0); pin(2, 1); pin(3, 32'hBFC0_0000); tick();
        drive(4'b0000, 0, '0, 0); pin(2, 0); tick();

        // Reset mid-PEND drops the redirect
        drive(4'b1000, 1, 32'hDEAD_0000, 0); tick();
        drive(4'b1000, 0, '0, 1); pin(0, 0); pin(1, 0); tick();
        drive(4'b0000, 0, '0, 0); pin(2, 0); pin(3, 0); pin(4, 0); pin(5, 0); tick();
        drive(4'b0000, 0, '0, 0); pin(2, 0); pin(3, 0); tick();

        // Watchdog with LIMIT=4: only the second burst trips it
        repeat (3) begin drive(4'b0100, 0, '0, 0); pin(5, 0); tick(); end
        drive(4'b0000, 0, '0, 0); pin(5, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 0, '0, 0); pin(5, (i == 4) ? 1 : 0); tick();
        end
        drive(4'b0000, 0, '0, 0); pin(5, 1); pin(4, 8); tick();
        drive(4'b0000, 0, '0, 0); pin(5, 1); tick();

        // Counter saturation from a forced near-full value
        drive(4'b0100, 0, '0, 0);
        @(negedge clock); #1;
        force dut.stall_count_q = 32'hFFFF_FFFE;
        preload = 1;
        #1;
        release dut.stall_count_q;
        tick();
        preload = 0;
        repeat (2) begin drive(4'b0100, 0, '0, 0); pin(4, 32'hFFFF_FFFF); tick(); end
        drive(4'b0000, 0, '0, 0); pin(4, 32'hFFFF_FFFF); tick();

        @(negedge clock); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the five-stage CPU. It merges per-stage stall requests into the 6-bit stall bus consumed by the PC register and the inter-stage latches. It sequences control-flow redirects from the exception unit into a one-cycle flush with a new fetch address, deferring the redirect while a memory access is in flight. It also keeps a saturating stall-cycle counter and a sticky stall watchdog for debug.

## Interface
Parameters:
- STALL_LIMIT, 255: consecutive PC-stall cycles after which the watchdog fires (1..65535).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall_req_if  in  1  fetch stage needs to hold.
- stall_req_id  in  1  decode stage needs to hold (load-use hazard).
- stall_req_ex  in  1  execute stage needs to hold (multi-cycle op).
- stall_req_mem  in  1  memory stage waiting on the bus; a transaction is in flight.
- redirect_valid  in  1  exception unit requests a redirect.
- redirect_target  in  32  fetch address to redirect to.
- redirect_ready  out  1  redirect accepted this cycle when high together with redirect_valid.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- flush  out  1  one-cycle pulse that invalidates all inter-stage latches.
- new_pc  out  32  next PC value, valid while flush is high; the PC register loads it in place of PC+4.
- stall_count  out  32  number of cycles with stall[0]=1, saturating at 0xFFFFFFFF.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- The FSM has three states: RUN, PEND, FLUSH. Reset enters RUN.
- In RUN, redirect_ready = ~stall_req_mem.
  - A redirect handshake (redirect_valid & redirect_ready) latches redirect_target and moves to FLUSH.
  - redirect_valid with stall_req_mem=1 latches the target without a handshake and moves to PEND. redirect_ready stays 0.
- In PEND, redirect_ready=0. When stall_req_mem falls, the FSM moves to FLUSH. redirect_valid/target are ignored; the latched target wins.
- In FLUSH, flush=1 and new_pc equals the latched target.
  - stall is forced to 0 so that every latch captures the bubble.
  - redirect_ready=0. The FSM returns to RUN on the next cycle unconditionally.
- Stall encoding outside FLUSH uses combinational priority, highest stage first:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- new_pc holds its last latched value when flush=0. Its reset value is 0.
- stall_count increments by 1 on every cycle with stall[0]=1 and holds at all-ones.
- The watchdog run counter is 16-bit.
  - It increments while stall[0]=1 and clears to 0 on any cycle with stall[0]=0.
  - When it reaches STALL_LIMIT, stall_timeout sets.
  - stall_timeout stays set until reset. It does not affect stall generation.
- Reset values:
  - stall=0 (forced to 0 while reset is high), flush=0, new_pc=0, redirect_ready=0.
  - stall_count=0, stall_timeout=0, run counter=0, state RUN.
- Reset asserted mid-PEND or mid-FLUSH drops the pending redirect. No flush is emitted afterward.

## Timing
- stall and redirect_ready are combinational from the request inputs and the current state, with zero-cycle latency.
- A handshake at edge N drives flush=1 and new_pc=target during cycle N+1, for exactly one cycle.
- In PEND, if stall_req_mem is first sampled low at edge M, flush is high during cycle M+1.
- Back-to-back redirects are spaced at least 2 cycles apart (FLUSH → RUN → accept).
- A redirect and a mem stall request asserted in the same RUN cycle go to PEND. The stall bus shows 6'b011111 that cycle.
- Stall requests present during FLUSH are masked for that cycle only. They re-apply in the following RUN cycle.
- stall_count and the run counter sample the stall value driven in the same cycle, including the forced 0 during FLUSH.
- stall_timeout rises on the edge where the run counter reaches STALL_LIMIT. With STALL_LIMIT=4 and stall[0] high from cycle 0, it is high from cycle 4.

## Test plan
- Stall priority: stall_req_id=1 and stall_req_if=1 → stall=6'b000111. Adding stall_req_mem=1 → 6'b011111. All requests low → 0.
- Immediate redirect: in RUN with stall_req_mem=0, pulse redirect_valid with target 0x0000_0380 → redirect_ready=1 the same cycle; next cycle flush=1, new_pc=0x0000_0380, stall=0; the cycle after, flush=0.
- Deferred redirect: hold stall_req_mem=1, assert redirect_valid with target 0xBFC0_0000, then change the target to 0x1234 for 3 cycles → redirect_ready stays 0. Drop stall_req_mem → flush pulses once with new_pc=0xBFC0_0000.
- Reset mid-PEND: enter PEND, assert reset for 1 cycle, drop stall_req_mem → no flush pulse. All outputs return to their reset values.
- Watchdog: STALL_LIMIT=4, stall_req_ex high for 3 cycles then low for 1 cycle then high for 5 cycles → stall_timeout rises only in the second burst. It stays high after the request drops; stall_count=8.
- Counter saturation: preload or force stall_count to 0xFFFF_FFFE, then stall for 3 cycles → stall_count=0xFFFF_FFFF and holds.
